// File: rtl/sc_or_split_pkg.sv
// Shared definitions for the OR-split decomposer: FSM state encoding and
// the width helper used to size the accepted-term counter.
package sc_or_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sc_or_split_lsb.sv
// Combinational lowest-set-bit isolator with a single-bit detector.
module sc_or_split_lsb #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  output logic [W-1:0] lowest,
  output logic         single
);

  logic [W-1:0] one;
  logic [W-1:0] data_minus_one;

  assign one            = {{(W-1){1'b0}}, 1'b1};
  assign data_minus_one = data - one;

  // Two's-complement trick: data & -data keeps only the least significant 1.
  assign lowest = data & (~data + one);
  assign single = (data != '0) && ((data & data_minus_one) == '0);

endmodule

// File: rtl/sc_or_split.sv
// Splits an OR-combined mask into one-hot terms, LSB first, with a
// valid/ready handshake and a done pulse after the final term.
module sc_or_split
  import sc_or_split_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input  logic                                        OR_SPLIT_CLOCK_50,
  input  logic                                        OR_SPLIT_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0]                 OR_SPLIT_data_In,
  input  logic                                        OR_SPLIT_load_In,
  input  logic                                        OR_SPLIT_ready_In,
  output logic [NUMBER_DATAWIDTH-1:0]                 OR_SPLIT_z_Out,
  output logic                                        OR_SPLIT_valid_Out,
  output logic                                        OR_SPLIT_last_Out,
  output logic                                        OR_SPLIT_busy_Out,
  output logic                                        OR_SPLIT_done_Out,
  output logic [count_width(NUMBER_DATAWIDTH)-1:0]    OR_SPLIT_count_Out
);

  localparam int W  = NUMBER_DATAWIDTH;
  localparam int CW = count_width(NUMBER_DATAWIDTH);

  state_t        state, state_next;
  logic [W-1:0]  rem, rem_next;
  logic [CW-1:0] count, count_next;
  logic          done, done_next;
  logic [W-1:0]  lowest;
  logic          single;
  logic          running;

  sc_or_split_lsb #(
    .W(W)
  ) u_lsb (
    .data   (rem),
    .lowest (lowest),
    .single (single)
  );

  assign running = (state == RUN);

  assign OR_SPLIT_z_Out     = running ? lowest : '0;
  assign OR_SPLIT_valid_Out = running;
  assign OR_SPLIT_busy_Out  = running;
  assign OR_SPLIT_last_Out  = running && single;
  assign OR_SPLIT_done_Out  = done;
  assign OR_SPLIT_count_Out = count;

  always_ff @(posedge OR_SPLIT_CLOCK_50) begin
    if (!OR_SPLIT_RESET_InLow) begin
      state <= IDLE;
      rem   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      count <= count_next;
      done  <= done_next;
    end
  end

  // Loads are only honoured in IDLE; in RUN the handshake alone advances rem.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    count_next = count;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (OR_SPLIT_load_In) begin
          count_next = '0;
          if (OR_SPLIT_data_In != '0) begin
            rem_next   = OR_SPLIT_data_In;
            state_next = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (OR_SPLIT_ready_In) begin
          rem_next   = rem & ~lowest;
          count_next = count + {{(CW-1){1'b0}}, 1'b1};
          if (single) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sc_or_split.sv
// Self-checking bench for sc_or_split: a queue-based term model checked every
// cycle, a per-mask OR/popcount scoreboard, and literal directed sequences.
module tb_sc_or_split;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data;
  logic         load;
  logic         ready;
  logic [W-1:0] z_o;
  logic         valid_o;
  logic         last_o;
  logic         busy_o;
  logic         done_o;
  logic [3:0]   count_o;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  logic [W-1:0] q[$];
  int           m_count = 0;
  bit           m_done = 0;
  logic [W-1:0] sb_mask = '0;
  logic [W-1:0] acc = '0;

  sc_or_split #(
    .NUMBER_DATAWIDTH(W)
  ) dut (
    .OR_SPLIT_CLOCK_50    (clk),
    .OR_SPLIT_RESET_InLow (rst_n),
    .OR_SPLIT_data_In     (data),
    .OR_SPLIT_load_In     (load),
    .OR_SPLIT_ready_In    (ready),
    .OR_SPLIT_z_Out       (z_o),
    .OR_SPLIT_valid_Out   (valid_o),
    .OR_SPLIT_last_Out    (last_o),
    .OR_SPLIT_busy_Out    (busy_o),
    .OR_SPLIT_done_Out    (done_o),
    .OR_SPLIT_count_Out   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change only on the falling edge so both edges see stable values.
  task automatic applyStimulus(input logic r, input logic l, input logic [W-1:0] d, input logic rd);
    @(negedge clk);
    rst_n = r;
    load  = l;
    data  = d;
    ready = rd;
  endtask

  task automatic pinOut(input string name, input logic [W-1:0] z, input logic v,
                        input logic l, input logic d, input int c);
    checkOutput({name, ".z"},     32'(z_o),     32'(z));
    checkOutput({name, ".valid"}, 32'(valid_o), 32'(v));
    checkOutput({name, ".last"},  32'(last_o),  32'(l));
    checkOutput({name, ".done"},  32'(done_o),  32'(d));
    checkOutput({name, ".count"}, 32'(count_o), 32'(c));
  endtask

  // Model: a pending-term queue filled from the mask's set bits, LSB first.
  always @(posedge clk) begin
    bit nd;
    nd = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_count = 0;
      acc     = '0;
    end else if (q.size() == 0) begin
      if (load) begin
        m_count = 0;
        sb_mask = data;
        acc     = '0;
        if (data == '0) nd = 1'b1;
        else
          for (int i = 0; i < W; i++)
            if (data[i]) q.push_back(W'(1 << i));
      end
    end else if (ready) begin
      if (valid_o) acc = acc | z_o;
      void'(q.pop_front());
      m_count++;
      if (q.size() == 0) nd = 1'b1;
    end
    m_done = nd;
  end

  always @(negedge clk) begin
    logic [W-1:0] exp_z;
    bit           exp_valid;
    if (check_en) begin
      exp_valid = (q.size() != 0);
      exp_z     = exp_valid ? q[0] : '0;
      checkOutput("model.valid", 32'(valid_o), 32'(exp_valid));
      checkOutput("model.busy",  32'(busy_o),  32'(exp_valid));
      checkOutput("model.z",     32'(z_o),     32'(exp_z));
      checkOutput("model.last",  32'(last_o),  32'(q.size() == 1));
      checkOutput("model.done",  32'(done_o),  32'(m_done));
      checkOutput("model.count", 32'(count_o), 32'(m_count));
      if (m_done) begin
        checkOutput("sb.or",    32'(acc),     32'(sb_mask));
        checkOutput("sb.count", 32'(count_o), 32'($countones(sb_mask)));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    data  = '0;
    ready = 1'b0;
    @(posedge clk);
    check_en = 1'b1;
    applyStimulus(0, 0, 8'h00, 0);
    pinOut("reset", 8'h00, 0, 0, 0, 0);
    checkOutput("reset.busy", 32'(busy_o), 32'd0);
    applyStimulus(1, 0, 8'h00, 0);

    $display("[TB] mask A5 with ready held high");
    applyStimulus(1, 1, 8'hA5, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("a5_t0", 8'h01, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("a5_t1", 8'h04, 1, 0, 0, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("a5_t2", 8'h20, 1, 0, 0, 2);
    applyStimulus(1, 0, 8'h00, 1); pinOut("a5_t3", 8'h80, 1, 1, 0, 3);
    applyStimulus(1, 0, 8'h00, 1); pinOut("a5_done", 8'h00, 0, 0, 1, 4);
    applyStimulus(1, 0, 8'h00, 1); pinOut("a5_after", 8'h00, 0, 0, 0, 4);

    $display("[TB] mask 0C with a three-cycle stall");
    applyStimulus(1, 1, 8'h0C, 0);
    applyStimulus(1, 0, 8'h00, 0); pinOut("0c_s0", 8'h04, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0); pinOut("0c_s1", 8'h04, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0); pinOut("0c_s2", 8'h04, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("0c_t0", 8'h04, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("0c_t1", 8'h08, 1, 1, 0, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("0c_done", 8'h00, 0, 0, 1, 2);

    $display("[TB] empty mask");
    applyStimulus(1, 1, 8'h00, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("00_done", 8'h00, 0, 0, 1, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("00_after", 8'h00, 0, 0, 0, 0);

    $display("[TB] load while busy, then load in the done cycle");
    applyStimulus(1, 1, 8'h03, 1);
    applyStimulus(1, 1, 8'hF0, 1); pinOut("03_t0", 8'h01, 1, 0, 0, 0);
    applyStimulus(1, 1, 8'hF0, 1); pinOut("03_t1", 8'h02, 1, 1, 0, 1);
    applyStimulus(1, 1, 8'hF0, 1); pinOut("03_done", 8'h00, 0, 0, 1, 2);
    applyStimulus(1, 0, 8'h00, 1); pinOut("f0_t0", 8'h10, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("f0_t1", 8'h20, 1, 0, 0, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("f0_t2", 8'h40, 1, 0, 0, 2);
    applyStimulus(1, 0, 8'h00, 1); pinOut("f0_t3", 8'h80, 1, 1, 0, 3);
    applyStimulus(1, 0, 8'h00, 1); pinOut("f0_done", 8'h00, 0, 0, 1, 4);

    $display("[TB] reset in the middle of mask FF");
    applyStimulus(1, 1, 8'hFF, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("ff_t0", 8'h01, 1, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("ff_t1", 8'h02, 1, 0, 0, 1);
    applyStimulus(1, 0, 8'h00, 1); pinOut("ff_t2", 8'h04, 1, 0, 0, 2);
    applyStimulus(0, 1, 8'h55, 1); pinOut("ff_t3", 8'h08, 1, 0, 0, 3);
    applyStimulus(1, 1, 8'h80, 1); pinOut("ff_rst", 8'h00, 0, 0, 0, 0);
    checkOutput("ff_rst.busy", 32'(busy_o), 32'd0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("80_t0", 8'h80, 1, 1, 0, 0);
    applyStimulus(1, 0, 8'h00, 1); pinOut("80_done", 8'h00, 0, 0, 1, 1);

    $display("[TB] random masks with random backpressure");
    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] m;
      bit           finished;
      m = (n == 0) ? 8'hFF : W'($urandom);
      finished = 1'b0;
      applyStimulus(1, 1, m, 1);
      for (int c = 0; c < 60 && !finished; c++) begin
        applyStimulus(1, 0, 8'h00, 1'($urandom_range(0, 1)));
        if (done_o) finished = 1'b1;
      end
      if (!finished) checkOutput("rand.timeout", 32'd0, 32'd1);
    end
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
